// File: rtl/ps2_pkg.sv
// Shared types and helpers for the multi-channel PS/2 device-to-host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ERR_PARITY   = 2'd0,
    ERR_FRAMING  = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } dec_state_e;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ps2_rx_chan.sv
// One PS/2 receive channel: pad synchronisers, clock glitch filter, frame
// decoder with timeout, byte FIFO and clock-inhibit when the FIFO is full.
module ps2_rx_chan
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  input  logic       pop,
  output logic       fifo_empty,
  output logic [7:0] fifo_data,
  output logic       err_valid,
  output logic [1:0] err_code
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  dec_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_valid_q, err_valid_d;
  err_code_e     err_code_q, err_code_d;
  logic          push;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, do_pop;
  logic          oe_q, oe_d;

  // The filtered level only follows the pad after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FILT_MAX) filt_d = clk_s2_q;
      else                    fcnt_d = fcnt_q + FW'(1);
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    to_cnt_d    = '0;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    push        = 1'b0;
    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!dat_s2_q) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_FRAMING;
          end else if (!(^{shift_q, par_q})) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_PARITY;
          end else if (full && !do_pop) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_OVERFLOW;
          end else begin
            push = 1'b1;
          end
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == TO_MAX) begin
        state_d     = ST_IDLE;
        err_valid_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  // A push into a full FIFO is legal when the arbiter pops it in the same cycle.
  assign do_pop     = pop & ~fifo_empty;
  assign fifo_empty = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign fifo_data  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(do_pop);
    oe_d     = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_PARITY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      oe_q        <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk_in;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data_in;
      dat_s2_q    <= dat_s1_q;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      oe_q        <= oe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign ps2_clk_oe = oe_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;

endmodule

// File: rtl/ps2_rx_array.sv
// CHANNELS independent PS/2 receivers merged by a round-robin arbiter into a
// single valid/ready byte stream tagged with the source channel.
module ps2_rx_array
  import ps2_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         ps2_clk_in,
  input  logic [CHANNELS-1:0]         ps2_data_in,
  output logic [CHANNELS-1:0]         ps2_clk_oe,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_data,
  output logic [chan_w(CHANNELS)-1:0] out_chan,
  output logic [CHANNELS-1:0]         err_valid,
  output logic [2*CHANNELS-1:0]       err_code
);

  localparam int CHW = chan_w(CHANNELS);

  logic [CHANNELS-1:0] empty, pop;
  logic [7:0]          fdata [CHANNELS];
  logic [CHW-1:0]      ptr_q, ptr_d, grant;
  logic                found, load;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_data_q, out_data_d;
  logic [CHW-1:0]      out_chan_q, out_chan_d;

  function automatic logic [CHW-1:0] rr_idx(input logic [CHW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CHANNELS) s = s - CHANNELS;
    return CHW'(s);
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    ps2_rx_chan #(
      .FIFO_DEPTH    (FIFO_DEPTH),
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2_clk_in (ps2_clk_in[i]),
      .ps2_data_in(ps2_data_in[i]),
      .ps2_clk_oe (ps2_clk_oe[i]),
      .pop        (pop[i]),
      .fifo_empty (empty[i]),
      .fifo_data  (fdata[i]),
      .err_valid  (err_valid[i]),
      .err_code   (err_code[2*i +: 2])
    );
  end

  // Scan from the pointer upwards; the lowest offset that has data wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (!empty[rr_idx(ptr_q, k)]) begin
        found = 1'b1;
        grant = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    load        = found && (!out_valid_q || out_ready);
    pop         = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (load) begin
      pop[grant]  = 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = fdata[grant];
      out_chan_d  = grant;
      ptr_d       = rr_idx(grant, 1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_ps2_rx_array.sv
// Bench for ps2_rx_array: PS/2 device models per channel, a frame-level
// reference of expected bytes/errors per channel, and an output monitor.
`timescale 1ns/1ps
module tb_ps2_rx_array;

  localparam int CH   = 2;
  localparam int FD   = 4;
  localparam int FL   = 4;
  localparam int TO   = 1000;
  localparam int HALF = 40;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] ps2_clk_in, ps2_data_in, ps2_clk_oe, err_valid;
  logic          out_valid, out_ready;
  logic [7:0]    out_data;
  logic [0:0]    out_chan;
  logic [2*CH-1:0] err_code;

  ps2_rx_array #(
    .CHANNELS(CH), .FIFO_DEPTH(FD), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .err_valid(err_valid), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_err, cyc, rdy_mode, model_last;
  int expb[CH][$], obsb[CH][$], expe[CH][$], obse[CH][$];
  int obs_ord[$], obs_cyc[$];
  int err_cyc[CH], last_fall[CH];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      out_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
    end
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      obsb[int'(out_chan)].push_back(int'(out_data));
      obs_ord.push_back(int'(out_chan));
      obs_cyc.push_back(cyc);
    end
    for (int c = 0; c < CH; c++) begin
      if (err_valid[c]) begin
        obse[c].push_back(int'(err_code[2*c +: 2]));
        err_cyc[c] <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  // Device side of one frame: start, 8 data LSB first, odd parity, stop.
  task automatic send(input int ch, input logic [7:0] b, input bit bad_par,
                      input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data_in[ch] = bits[i];
      tick(HALF);
      ps2_clk_in[ch] = 1'b0;
      last_fall[ch]  = cyc;
      tick(HALF);
      ps2_clk_in[ch] = 1'b1;
    end
    ps2_data_in[ch] = 1'b1;
  endtask

  // Reference outcome of a complete frame from the receive rules.
  task automatic frame(input int ch, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_stop)      expe[ch].push_back(1);
    else if (bad_par)  expe[ch].push_back(0);
    else if (rdy_mode == 0 && expb[ch].size() >= FD + 1) expe[ch].push_back(3);
    else begin
      expb[ch].push_back(int'(b));
      model_last = ch;
    end
    send(ch, b, bad_par, bad_stop, 11);
  endtask

  task automatic rand_frame(input int ch);
    logic [7:0] b;
    int r;
    tick($urandom_range(0, 120));
    b = 8'($urandom);
    r = $urandom_range(0, 5);
    frame(ch, b, (r == 1 || r == 3), (r == 2 || r == 3));
  endtask

  task automatic compare_all(input string tag);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s ch%0d byte count", tag, c), obsb[c].size(), expb[c].size());
      for (int i = 0; i < expb[c].size() && i < obsb[c].size(); i++)
        chk($sformatf("%s ch%0d byte %0d", tag, c, i), obsb[c][i], expb[c][i]);
      chk($sformatf("%s ch%0d err count", tag, c), obse[c].size(), expe[c].size());
      for (int i = 0; i < expe[c].size() && i < obse[c].size(); i++)
        chk($sformatf("%s ch%0d err code %0d", tag, c, i), obse[c][i], expe[c][i]);
      expb[c].delete(); obsb[c].delete(); expe[c].delete(); obse[c].delete();
    end
    obs_ord.delete();
    obs_cyc.delete();
  endtask

  task automatic rr_pair(input string tag);
    int first;
    first = (model_last + 1) % CH;
    fork
      frame(0, 8'h11, 1'b0, 1'b0);
      frame(1, 8'h22, 1'b0, 1'b0);
    join
    tick(30);
    chk({tag, " grant count"}, obs_ord.size(), 2);
    if (obs_ord.size() == 2) begin
      chk({tag, " first grant"}, obs_ord[0], first);
      chk({tag, " second grant"}, obs_ord[1], 1 - first);
      chk({tag, " back-to-back"}, obs_cyc[1] - obs_cyc[0], 1);
    end
    model_last = 1 - first;
    compare_all(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " out_chan"}, out_chan, 0);
    chk({tag, " err_valid"}, err_valid, 0);
    chk({tag, " err_code"}, err_code, 0);
    chk({tag, " ps2_clk_oe"}, ps2_clk_oe, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    ps2_clk_in  = '1;
    ps2_data_in = '1;
    rdy_mode    = 0;
    model_last  = CH - 1;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(5);

    rdy_mode = 1;
    frame(0, 8'h1C, 1'b0, 1'b0);
    tick(30);
    compare_all("basic 0x1C");

    frame(1, 8'hF0, 1'b1, 1'b0);
    frame(1, 8'hF0, 1'b0, 1'b0);
    tick(30);
    compare_all("parity");

    send(0, 8'hA5, 1'b0, 1'b0, 5);
    expe[0].push_back(2);
    tick(TO + 50);
    chk("timeout latency", err_cyc[0] - last_fall[0], 2 + FL + TO);
    compare_all("timeout");
    frame(0, 8'h1C, 1'b0, 1'b0);
    tick(30);
    compare_all("after timeout");

    ps2_clk_in[0] = 1'b0;
    tick(2);
    ps2_clk_in[0] = 1'b1;
    tick(40);
    compare_all("glitch");
    frame(0, 8'h5A, 1'b0, 1'b0);
    tick(30);
    compare_all("after glitch");

    rdy_mode = 0;
    tick(3);
    for (int i = 0; i < FD; i++) frame(0, 8'($urandom), 1'b0, 1'b0);
    tick(20);
    chk("inhibit below full", ps2_clk_oe[0], 0);
    frame(0, 8'($urandom), 1'b0, 1'b0);
    tick(20);
    chk("inhibit when full", ps2_clk_oe[0], 1);
    chk("held out_valid", out_valid, 1);
    chk("held out_data", out_data, expb[0][0]);
    frame(0, 8'h77, 1'b0, 1'b0);
    tick(20);
    rdy_mode = 1;
    tick(30);
    chk("inhibit released", ps2_clk_oe[0], 0);
    compare_all("overflow");

    rdy_mode = 2;
    for (int it = 0; it < 8; it++) begin
      fork
        rand_frame(0);
        rand_frame(1);
      join
    end
    tick(40);
    rdy_mode = 1;
    tick(20);
    compare_all("random");

    send(1, 8'h3C, 1'b0, 1'b0, 4);
    rst_n = 1'b0;
    tick(2);
    check_reset_outputs("mid-frame reset");
    rst_n = 1'b1;
    model_last = CH - 1;
    tick(TO + 50);
    compare_all("mid-frame reset");

    frame(1, 8'h5E, 1'b0, 1'b0);
    tick(30);
    compare_all("rr setup ch1");
    rr_pair("rr pair 1");
    frame(0, 8'h6B, 1'b0, 1'b0);
    tick(30);
    compare_all("rr setup ch0");
    rr_pair("rr pair 2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
